// File: rtl/ddr_test_pkg.sv
// ddr_test_pkg: shared constants, FSM states and pattern helpers for the DDR burst tester
//   INSTR_WR/INSTR_RD : MCB user-port instruction codes
//   state_t           : tester FSM states
//   lfsr_next         : one step of the x^32+x^22+x^2+x+1 Fibonacci LFSR
//   pattern_seed      : generator seed for a pass (incrementing or LFSR mode)
package ddr_test_pkg;
  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;
  typedef enum logic [2:0] {WAIT_CAL, IDLE, FILL, WCMD, RCMD, DRAIN, FIN} state_t;
  // Incrementing mode needs pass_count<<24 plus the word index, so 48 bits of state
  localparam int SEED_W = 48;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0000;
  // Feedback from bits 31, 21, 1, 0 (polynomial terms x^32, x^22, x^2, x)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction
  function automatic logic [SEED_W-1:0] pattern_seed(input int pattern, input logic [15:0] pass_num);
    return pattern == 1 ? SEED_W'(LFSR_SEED ^ {16'h0, pass_num}) : SEED_W'({pass_num, 24'h0});
  endfunction
endpackage

// File: rtl/ddr_pattern_gen.sv
// ddr_pattern_gen: data pattern generator, one instance each for the writer and the checker
//   clk, reset (sync, active-low)
//   load/seed : restart the sequence from seed
//   adv       : step to the next word
//   word      : current pattern word (incrementing value or replicated 32-bit LFSR)
module ddr_pattern_gen
  import ddr_test_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int PATTERN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [SEED_W-1:0] seed,
  input  logic              adv,
  output logic [DATA_W-1:0] word
);
  logic [SEED_W-1:0] st;
  always_ff @(posedge clk) begin
    if (!reset) st <= '0;
    else if (load) st <= seed;
    else if (adv) st <= PATTERN == 1 ? SEED_W'(lfsr_next(st[31:0])) : st + 1'b1;
  end
  assign word = PATTERN == 1 ? {(DATA_W/32){st[31:0]}} : DATA_W'(st);
endmodule

// File: rtl/ddr_burst_tester.sv
// ddr_burst_tester: self-checking burst write/read-back traffic generator for one MCB user port
//   clk, reset (sync, active-low), calib_done (async), start
//   cmd_*  : command FIFO interface (cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, cmd_full)
//   wr_*   : write FIFO interface (wr_en, wr_data, wr_mask, wr_full)
//   rd_*   : read FIFO interface (rd_en, rd_data, rd_empty)
//   busy, done, pass, timeout, err_count, first_err_addr, pass_count : status
module ddr_burst_tester
  import ddr_test_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 30,
  parameter int BURST_LEN  = 16,
  parameter int NUM_BURSTS = 256,
  parameter int BASE_ADDR  = 0,
  parameter int PATTERN    = 0,
  parameter int TIMEOUT    = 4096,
  parameter int LOOP       = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                calib_done,
  input  logic                start,
  output logic                cmd_en,
  output logic [2:0]          cmd_instr,
  output logic [5:0]          cmd_bl,
  output logic [ADDR_W-1:0]   cmd_byte_addr,
  input  logic                cmd_full,
  output logic                wr_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_mask,
  input  logic                wr_full,
  output logic                rd_en,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                rd_empty,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [15:0]         pass_count
);
  localparam int BYTES = DATA_W/8;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN*BYTES);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_t state;
  logic [1:0] cal_q;
  logic [31:0] burst, widx, wcnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] chk_word;
  logic go, seed_load, last_word, last_burst, in_cmd;
  assign go = state == IDLE && cal_q[1] && (start || LOOP != 0);
  assign last_word = widx == BURST_LEN-1;
  assign last_burst = burst == NUM_BURSTS-1;
  assign in_cmd = state == WCMD || state == RCMD;
  // Strobes are decoded from registered state and gated by the FIFO flags, so a push/pop never lands on a full/empty FIFO
  assign cmd_en = in_cmd && !cmd_full;
  assign cmd_instr = state == RCMD ? INSTR_RD : INSTR_WR;
  assign cmd_bl = in_cmd ? 6'(BURST_LEN-1) : 6'd0;
  assign cmd_byte_addr = addr;
  assign wr_en = state == FILL && !wr_full;
  assign wr_mask = '0;
  assign rd_en = state == DRAIN && !rd_empty;
  // Both generators restart together at pass start; the checker restarts again before the read phase
  assign seed_load = go || (state == WCMD && cmd_en && last_burst);
  ddr_pattern_gen #(.DATA_W(DATA_W), .PATTERN(PATTERN)) u_wr (
    .clk(clk), .reset(reset), .load(seed_load), .seed(pattern_seed(PATTERN, pass_count)),
    .adv(wr_en), .word(wr_data)
  );
  ddr_pattern_gen #(.DATA_W(DATA_W), .PATTERN(PATTERN)) u_chk (
    .clk(clk), .reset(reset), .load(seed_load), .seed(pattern_seed(PATTERN, pass_count)),
    .adv(rd_en), .word(chk_word)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      cal_q <= '0;
      state <= WAIT_CAL;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
      err_count <= '0;
      first_err_addr <= '0;
      pass_count <= '0;
      addr <= '0;
      burst <= '0;
      widx <= '0;
      wcnt <= '0;
    end else begin
      cal_q <= {cal_q[0], calib_done};
      done <= 1'b0;
      if (state != WAIT_CAL && !cal_q[1]) begin
        state <= WAIT_CAL;
        busy <= 1'b0;
      end else begin
        case (state)
          WAIT_CAL: if (cal_q[1]) state <= IDLE;
          IDLE: if (go) begin
            err_count <= '0;
            first_err_addr <= '0;
            timeout <= 1'b0;
            pass <= 1'b0;
            busy <= 1'b1;
            burst <= '0;
            addr <= BASE;
            widx <= '0;
            state <= FILL;
          end
          FILL: if (wr_en) begin
            widx <= last_word ? '0 : widx + 1;
            if (last_word) state <= WCMD;
          end
          WCMD: if (cmd_en) begin
            addr <= last_burst ? BASE : addr + STEP;
            burst <= last_burst ? '0 : burst + 1;
            state <= last_burst ? RCMD : FILL;
          end
          RCMD: if (cmd_en) begin
            wcnt <= '0;
            widx <= '0;
            state <= DRAIN;
          end
          DRAIN: if (rd_en) begin
            // wcnt counts cycles since the last accepted word, this one included
            wcnt <= 32'd1;
            if (rd_data != chk_word) begin
              err_count <= err_count + 16'(err_count != 16'hFFFF);
              if (err_count == '0) first_err_addr <= addr + ADDR_W'(widx * BYTES);
            end
            widx <= last_word ? '0 : widx + 1;
            if (last_word) begin
              addr <= addr + STEP;
              burst <= burst + 1;
              state <= last_burst ? FIN : RCMD;
              done <= last_burst;
            end
          end else if (wcnt + 1 == TIMEOUT) begin
            timeout <= 1'b1;
            done <= 1'b1;
            state <= FIN;
          end else begin
            wcnt <= wcnt + 1;
          end
          FIN: begin
            pass <= err_count == '0 && !timeout;
            pass_count <= pass_count + 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
          default: state <= WAIT_CAL;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ddr_burst_tester.sv
// tb_ddr_burst_tester: randomized MCB port model with an ideal memory checking the burst tester
module tb_ddr_burst_tester;
  import ddr_test_pkg::*;
  localparam int DW = 64, AW = 30, BL = 16, NB = 4, TO = 64, BY = DW/8;
  logic clk = 0, reset = 0, calib_done = 0, start = 0;
  logic cmd_full = 0, wr_full = 0, rd_empty = 1;
  logic [DW-1:0] rd_data = '0;
  logic cmd_en, wr_en, rd_en, busy, done, pass, timeout;
  logic [2:0] cmd_instr;
  logic [5:0] cmd_bl;
  logic [AW-1:0] cmd_byte_addr, first_err_addr;
  logic [DW-1:0] wr_data;
  logic [BY-1:0] wr_mask;
  logic [15:0] err_count, pass_count;
  always #5 clk = ~clk;
  ddr_burst_tester #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .NUM_BURSTS(NB), .BASE_ADDR(0),
    .PATTERN(0), .TIMEOUT(TO), .LOOP(0)
  ) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .start(start),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .cmd_full(cmd_full), .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask), .wr_full(wr_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
    .pass_count(pass_count)
  );
  logic [DW-1:0] mem [int];
  logic [DW-1:0] wq[$], rdq[$];
  int errors = 0, checks = 0, cyc = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  int cmd_n = 0, wk = 0, p = 0;
  bit stall = 0, corrupt = 0, drop = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One clock cycle of the port model: drive flags at negedge, then act on the strobes the DUT shows
  task automatic tick();
    bit rd;
    int b;
    logic [DW-1:0] w;
    @(negedge clk);
    wr_full = stall && $urandom_range(1) == 1;
    cmd_full = stall && $urandom_range(1) == 1;
    rd_empty = rdq.size() == 0 || (stall && $urandom_range(1) == 1);
    rd_data = rdq.size() != 0 ? rdq[0] : '0;
    #1;
    cyc++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (wr_en) begin
      chk("push_while_full", 64'(wr_full), 0);
      chk("wr_data", wr_data, 64'(wk) + (64'(p) << 24));
      wq.push_back(wr_data);
      wk++;
    end
    if (cmd_en) begin
      rd = cmd_n >= NB;
      b = cmd_n % NB;
      chk("cmd_instr", 64'(cmd_instr), rd ? 64'(INSTR_RD) : 64'(INSTR_WR));
      chk("cmd_bl", 64'(cmd_bl), BL-1);
      chk("cmd_addr", 64'(cmd_byte_addr), 64'(b*BL*BY));
      if (!rd) begin
        chk("words_before_wcmd", 64'(wq.size()), BL);
        for (int i = 0; i < BL; i++) if (wq.size() != 0) mem[b*BL+i] = wq.pop_front();
      end else begin
        for (int i = 0; i < BL; i++) begin
          w = mem.exists(b*BL+i) ? mem[b*BL+i] : '1;
          if (corrupt && b == 2 && i == 5) w[3] = ~w[3];
          if (!(drop && b == NB-1 && i == BL-1)) rdq.push_back(w);
        end
      end
      cmd_n++;
    end
    if (rd_en) begin
      chk("pop_while_empty", 64'(rd_empty), 0);
      void'(rdq.pop_front());
      acc_cyc = cyc;
    end
  endtask
  task automatic begin_pass();
    cmd_n = 0;
    wk = 0;
    wq.delete();
    rdq.delete();
    mem.delete();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_done(input string tag);
    int n0, i;
    n0 = done_cnt;
    i = 0;
    while (done_cnt == n0 && i < 20000) begin
      tick();
      i++;
    end
    tick();
    tick();
    chk({tag, "_done_pulses"}, 64'(done_cnt - n0), 1);
  endtask
  task automatic check_result(input string tag, input bit ep, input int ee, input int ef, input bit et);
    p++;
    chk({tag, "_pass"}, 64'(pass), 64'(ep));
    chk({tag, "_err_count"}, 64'(err_count), 64'(ee));
    chk({tag, "_first_err_addr"}, 64'(first_err_addr), 64'(ef));
    chk({tag, "_timeout"}, 64'(timeout), 64'(et));
    chk({tag, "_pass_count"}, 64'(pass_count), 64'(p));
    chk({tag, "_busy"}, 64'(busy), 0);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, 64'({cmd_en, wr_en, rd_en, busy, done, pass, timeout}), 0);
    chk({tag, "_cmd"}, 64'({cmd_instr, cmd_bl, cmd_byte_addr}), 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_wr_mask"}, 64'(wr_mask), 0);
    chk({tag, "_counts"}, 64'({err_count, pass_count}), 0);
    chk({tag, "_first_err_addr"}, 64'(first_err_addr), 0);
  endtask
  initial begin
    int n, k;
    repeat (3) tick();
    check_zero("reset");
    reset = 1;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      n += int'(cmd_en) + int'(wr_en) + int'(rd_en);
    end
    chk("strobes_before_cal", 64'(n), 0);
    calib_done = 1;
    repeat (4) tick();
    chk("idle_busy", 64'(busy), 0);
    begin_pass();
    wait_done("ideal");
    check_result("ideal", 1, 0, 0, 0);
    corrupt = 1;
    begin_pass();
    wait_done("corrupt");
    check_result("corrupt", 0, 1, 2*BL*BY + 5*BY, 0);
    corrupt = 0;
    stall = 1;
    begin_pass();
    wait_done("stall");
    check_result("stall", 1, 0, 0, 0);
    stall = 0;
    drop = 1;
    begin_pass();
    wait_done("drop");
    chk("timeout_spacing", 64'(done_cyc - acc_cyc), TO);
    check_result("drop", 0, 0, 0, 1);
    drop = 0;
    begin_pass();
    k = 0;
    while (!(rd_en && cmd_n > NB) && k < 5000) begin
      tick();
      k++;
    end
    chk("reached_drain", 64'(rd_en), 1);
    reset = 0;
    tick();
    check_zero("mid_drain_reset");
    reset = 1;
    p = 0;
    repeat (5) tick();
    begin_pass();
    k = 0;
    while (wk < 5 && k < 1000) begin
      tick();
      k++;
    end
    calib_done = 0;
    n = done_cnt;
    k = 0;
    while (wr_en && k < 5) begin
      tick();
      k++;
    end
    chk("abort_wr_en", 64'(wr_en), 0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      k += int'(cmd_en) + int'(wr_en) + int'(rd_en);
    end
    chk("abort_strobes", 64'(k), 0);
    chk("abort_state", 64'(dut.state), 64'(WAIT_CAL));
    chk("abort_no_done", 64'(done_cnt - n), 0);
    calib_done = 1;
    repeat (5) tick();
    begin_pass();
    wait_done("recover");
    check_result("recover", 1, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
